branch_predictor: RTL

- IF-stage direction predictor and target buffer; the predicting counterpart of the EX-stage branch resolver.
- IF presents a fetch PC and receives a registered taken/target prediction one cycle later.
- EX returns the resolved outcome. The block trains its tables and raises a registered redirect on misprediction.
- Direct-mapped BTB; each entry holds a 2-bit saturating counter.

---
 rtl/branch_predictor.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// IF-stage direct-mapped BTB with 2-bit counters, trained and checked at EX.
// Optional return-address stack enabled by defining BRANCH_PREDICTOR_RAS_EN.
module branch_predictor #(
    parameter int ENTRIES   = 16,
    parameter int RAS_DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    input  logic        if_flush,
    output logic        pred_valid,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ex_valid,
    input  logic        ex_is_bj,
    input  logic [31:0] ex_pc,
    input  logic        ex_branch,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    input  logic        ex_is_call,
    input  logic        ex_is_ret,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    logic [ENTRIES-1:0] r_valid;
    logic [ENTRIES-1:0] r_is_ret;
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [31:0]        r_target [ENTRIES];
    logic [1:0]         r_cnt    [ENTRIES];

    logic        r_pred_valid;
    logic        r_pred_taken;
    logic [31:0] r_pred_target;
    logic        r_redirect_valid;
    logic [31:0] r_redirect_pc;

    logic [IDX_W-1:0] w_if_idx;
    logic [TAG_W-1:0] w_if_tag;
    logic             w_if_hit;
    logic             w_if_taken;
    logic [31:0]      w_if_tgt;
    logic [31:0]      w_if_stored;

    logic [IDX_W-1:0] w_ex_idx;
    logic [TAG_W-1:0] w_ex_tag;
    logic             w_ex_upd;
    logic             w_ex_hit;
    logic             w_mispredict;
    logic [31:0]      w_ex_fall;

    assign w_if_idx    = if_pc[IDX_W+1:2];
    assign w_if_tag    = if_pc[31:IDX_W+2];
    assign w_if_hit    = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
    assign w_if_taken  = w_if_hit && r_cnt[w_if_idx][1];
    assign w_if_stored = r_target[w_if_idx];

    assign w_ex_idx  = ex_pc[IDX_W+1:2];
    assign w_ex_tag  = ex_pc[31:IDX_W+2];
    assign w_ex_upd  = ex_valid && ex_is_bj;
    assign w_ex_hit  = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
    assign w_ex_fall = ex_pc + 32'd4;

    assign w_mispredict = w_ex_upd &&
        ((ex_branch != ex_pred_taken) ||
         (ex_branch && (ex_target != ex_pred_target)));

`ifdef BRANCH_PREDICTOR_RAS_EN
    localparam int RP_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW   = RP_W + 1;

    logic [31:0]   r_ras [RAS_DEPTH];
    logic [RP_W-1:0] r_ras_ptr;
    logic [CW-1:0]   r_ras_cnt;
    logic [RP_W-1:0] w_ras_top;
    logic [RP_W-1:0] w_ras_nxt;

    assign w_ras_top = (r_ras_ptr == '0) ? RP_W'(RAS_DEPTH - 1)
                                         : r_ras_ptr - 1'b1;
    assign w_ras_nxt = (r_ras_ptr == RP_W'(RAS_DEPTH - 1)) ? '0
                                                           : r_ras_ptr + 1'b1;

    // Return entries prefer the live stack top; empty stack falls back.
    assign w_if_tgt = (r_is_ret[w_if_idx] && (r_ras_cnt != '0))
                    ? r_ras[w_ras_top] : w_if_stored;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ras_ptr <= '0;
            r_ras_cnt <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                r_ras[i] <= '0;
            end
        end else if (w_ex_upd) begin
            if (ex_is_call) begin
                r_ras[r_ras_ptr] <= w_ex_fall;
                r_ras_ptr        <= w_ras_nxt;
                if (r_ras_cnt != CW'(RAS_DEPTH)) begin
                    r_ras_cnt <= r_ras_cnt + 1'b1;
                end
            end else if (ex_is_ret && (r_ras_cnt != '0)) begin
                r_ras_ptr <= w_ras_top;
                r_ras_cnt <= r_ras_cnt - 1'b1;
            end
        end
    end
`else
    logic w_unused;
    assign w_if_tgt = w_if_stored;
    assign w_unused = ex_is_call ^ (^r_is_ret) ^ RAS_DEPTH[0];
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid  <= '0;
            r_is_ret <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_cnt[i]    <= 2'b01;
            end
        end else if (w_ex_upd) begin
            if (w_ex_hit) begin
                if (ex_branch) begin
                    r_target[w_ex_idx] <= ex_target;
                    if (r_cnt[w_ex_idx] != 2'b11) begin
                        r_cnt[w_ex_idx] <= r_cnt[w_ex_idx] + 2'd1;
                    end
                end else if (r_cnt[w_ex_idx] != 2'b00) begin
                    r_cnt[w_ex_idx] <= r_cnt[w_ex_idx] - 2'd1;
                end
            end else if (ex_branch) begin
                r_valid[w_ex_idx]  <= 1'b1;
                r_is_ret[w_ex_idx] <= ex_is_ret;
                r_tag[w_ex_idx]    <= w_ex_tag;
                r_target[w_ex_idx] <= ex_target;
                r_cnt[w_ex_idx]    <= 2'b10;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pred_valid     <= 1'b0;
            r_pred_taken     <= 1'b0;
            r_pred_target    <= '0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            r_pred_valid     <= if_valid;
            r_redirect_valid <= w_mispredict;
            if (if_valid) begin
                r_pred_taken  <= w_if_taken;
                r_pred_target <= w_if_taken ? w_if_tgt : if_pc + 32'd4;
            end
            if (w_mispredict) begin
                r_redirect_pc <= ex_branch ? ex_target : w_ex_fall;
            end
        end
    end

    assign pred_valid     = r_pred_valid && !if_flush;
    assign pred_taken     = r_pred_taken;
    assign pred_target    = r_pred_target;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;

endmodule
